// File: rtl/gray_mult_sched_pkg.sv
// Shared types and float field constants for the grayscale multiply scheduler.
// Constant exponents are the biased exponents of the R/G/B luma weights.
package gray_mult_sched_pkg;

   localparam int unsigned MANT_W     = 23;
   localparam int unsigned EXP_W      = 8;
   localparam int unsigned FLOAT_W    = 1 + EXP_W + MANT_W;
   localparam int unsigned EXP_CALC_W = 10;
   localparam int unsigned SHIFT_W    = 5;

   localparam int unsigned RED_EXP_C   = 125;
   localparam int unsigned GREEN_EXP_C = 126;
   localparam int unsigned BLUE_EXP_C  = 123;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRun,
      StPack,
      StOut
   } state_e;

endpackage

// File: rtl/gray_mult_sched_pix2fp.sv
// Converts an integer pixel channel into a normalized {1, mantissa} operand,
// its biased exponent and a zero flag.
module gray_pix2fp
   import gray_mult_sched_pkg::*;
#(
   parameter int unsigned PIXEL_WIDTH    = 8,
   parameter int unsigned MANTISSA_WIDTH = MANT_W,
   parameter int unsigned EXPONENT_WIDTH = EXP_W,
   parameter int unsigned BIAS           = 127
) (
   input  logic [PIXEL_WIDTH-1:0]    pix_i,
   output logic [MANTISSA_WIDTH:0]   op_o,
   output logic [EXPONENT_WIDTH-1:0] exp_o,
   output logic                      zero_o
);

   localparam int unsigned OpW   = MANTISSA_WIDTH + 1;
   localparam int unsigned LeadW = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;

   logic [LeadW-1:0] lead;

   always_comb begin
      lead = '0;
      for (int i = 0; i < PIXEL_WIDTH; i++) begin
         if (pix_i[i]) begin
            lead = LeadW'(i);
         end
      end
      zero_o = (pix_i == '0);
      if (zero_o) begin
         // Zero has no leading one; emit 1.0 so the multiplier sees a legal operand.
         op_o  = {1'b1, {MANTISSA_WIDTH{1'b0}}};
         exp_o = '0;
      end else begin
         op_o  = OpW'(pix_i) << (MANTISSA_WIDTH - 32'(lead));
         exp_o = EXPONENT_WIDTH'(BIAS + 32'(lead));
      end
   end

endmodule

// File: rtl/gray_mult_sched.sv
// Sequences one pixel through an external mantissa multiplier and packs the three
// weighted channels into single-precision floats.
module gray_mult_sched
   import gray_mult_sched_pkg::*;
#(
   parameter int unsigned PIXEL_WIDTH    = 8,
   parameter int unsigned MANTISSA_WIDTH = MANT_W,
   parameter int unsigned EXPONENT_WIDTH = EXP_W,
   parameter int unsigned BIAS           = 127,
   parameter int unsigned RED_EXP        = RED_EXP_C,
   parameter int unsigned GREEN_EXP      = GREEN_EXP_C,
   parameter int unsigned BLUE_EXP       = BLUE_EXP_C,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                                 clk_i_fix_multi,
   input  logic                                 rstn_i_fix_multi,
   input  logic                                 s_valid_i,
   output logic                                 s_ready_o,
   input  logic [PIXEL_WIDTH-1:0]               s_pix_r_i,
   input  logic [PIXEL_WIDTH-1:0]               s_pix_g_i,
   input  logic [PIXEL_WIDTH-1:0]               s_pix_b_i,
   output logic                                 mult_rstn_o,
   output logic                                 mult_en_o,
   output logic [MANTISSA_WIDTH:0]              mult_r_o,
   output logic [MANTISSA_WIDTH:0]              mult_g_o,
   output logic [MANTISSA_WIDTH:0]              mult_b_o,
   input  logic [MANTISSA_WIDTH:0]              mult_r_i,
   input  logic [MANTISSA_WIDTH:0]              mult_g_i,
   input  logic [MANTISSA_WIDTH:0]              mult_b_i,
   input  logic [SHIFT_W-1:0]                   mult_exp_r_i,
   input  logic [SHIFT_W-1:0]                   mult_exp_g_i,
   input  logic [SHIFT_W-1:0]                   mult_exp_b_i,
   input  logic                                 mult_done_i,
   output logic                                 m_valid_o,
   input  logic                                 m_ready_i,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] m_r_o,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] m_g_o,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] m_b_o,
   output logic                                 busy_o,
   output logic                                 timeout_err_o
);

   localparam int unsigned FW   = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   state_e state_q, state_d;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic s_ready_q, s_ready_d;
   logic mult_rstn_q, mult_rstn_d;
   logic timeout_q, timeout_d;

   logic [2:0][MANTISSA_WIDTH:0]   op_q, op_d, conv_op;
   logic [2:0][EXPONENT_WIDTH-1:0] ep_q, ep_d, conv_exp;
   logic [2:0]                     zero_q, zero_d, conv_zero;
   logic [2:0][FW-1:0]             res_q, res_d;
   logic [2:0][PIXEL_WIDTH-1:0]    pix;

   assign pix = {s_pix_b_i, s_pix_g_i, s_pix_r_i};

   for (genvar c = 0; c < 3; c++) begin : g_conv
      gray_pix2fp #(
         .PIXEL_WIDTH   (PIXEL_WIDTH),
         .MANTISSA_WIDTH(MANTISSA_WIDTH),
         .EXPONENT_WIDTH(EXPONENT_WIDTH),
         .BIAS          (BIAS)
      ) u_pix2fp (
         .pix_i (pix[c]),
         .op_o  (conv_op[c]),
         .exp_o (conv_exp[c]),
         .zero_o(conv_zero[c])
      );
   end

   // Exponent arithmetic is widened so intermediate sums cannot wrap.
   function automatic logic [FW-1:0] pack_fp(
      input logic                      zero,
      input logic [EXPONENT_WIDTH-1:0] ep,
      input int unsigned               ec,
      input logic [SHIFT_W-1:0]        shift,
      input logic [MANTISSA_WIDTH-1:0] mant
   );
      logic [EXPONENT_WIDTH-1:0] e;
      e = EXPONENT_WIDTH'(EXP_CALC_W'(ep) + EXP_CALC_W'(ec) - EXP_CALC_W'(BIAS)
                          + EXP_CALC_W'(1) - EXP_CALC_W'(shift));
      if (zero) begin
         return '0;
      end
      return {1'b0, e, mant};
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      op_d      = op_q;
      ep_d      = ep_q;
      zero_d    = zero_q;
      res_d     = res_q;

      unique case (state_q)
         StIdle: begin
            if (s_valid_i && s_ready_q) begin
               state_d = StLoad;
               op_d    = conv_op;
               ep_d    = conv_exp;
               zero_d  = conv_zero;
            end
         end
         StLoad: begin
            state_d = StRun;
            cnt_d   = '0;
         end
         StRun: begin
            if (mult_done_i) begin
               state_d = StPack;
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               state_d   = StIdle;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StPack: begin
            state_d  = StOut;
            res_d[0] = pack_fp(zero_q[0], ep_q[0], RED_EXP, mult_exp_r_i,
                               mult_r_i[MANTISSA_WIDTH-1:0]);
            res_d[1] = pack_fp(zero_q[1], ep_q[1], GREEN_EXP, mult_exp_g_i,
                               mult_g_i[MANTISSA_WIDTH-1:0]);
            res_d[2] = pack_fp(zero_q[2], ep_q[2], BLUE_EXP, mult_exp_b_i,
                               mult_b_i[MANTISSA_WIDTH-1:0]);
         end
         StOut: begin
            if (m_ready_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Registered so both come up one edge after reset release.
      s_ready_d   = (state_d == StIdle);
      mult_rstn_d = (state_d != StLoad);
   end

   always_ff @(posedge clk_i_fix_multi or negedge rstn_i_fix_multi) begin
      if (!rstn_i_fix_multi) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         s_ready_q   <= 1'b0;
         mult_rstn_q <= 1'b0;
         timeout_q   <= 1'b0;
         op_q        <= '0;
         ep_q        <= '0;
         zero_q      <= '0;
         res_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         s_ready_q   <= s_ready_d;
         mult_rstn_q <= mult_rstn_d;
         timeout_q   <= timeout_d;
         op_q        <= op_d;
         ep_q        <= ep_d;
         zero_q      <= zero_d;
         res_q       <= res_d;
      end
   end

   // The hidden bit of each product is implied by normalization.
   logic unused_hidden;
   assign unused_hidden = ^{mult_r_i[MANTISSA_WIDTH], mult_g_i[MANTISSA_WIDTH],
                            mult_b_i[MANTISSA_WIDTH]};

   assign s_ready_o     = s_ready_q;
   assign mult_rstn_o   = mult_rstn_q;
   assign mult_en_o     = (state_q == StRun);
   assign mult_r_o      = op_q[0];
   assign mult_g_o      = op_q[1];
   assign mult_b_o      = op_q[2];
   assign m_valid_o     = (state_q == StOut);
   assign m_r_o         = res_q[0];
   assign m_g_o         = res_q[1];
   assign m_b_o         = res_q[2];
   assign busy_o        = (state_q != StIdle);
   assign timeout_err_o = timeout_q;

endmodule
